// File: rtl/oh_stimulus_loader_pkg.sv
// Shared definitions for the stimulus loader and the stimulus driver:
// driver mode encodings, loader FSM states and the state-to-mode mapping.
package oh_stimulus_loader_pkg;

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_READ = 2'b01;
  localparam logic [1:0] MODE_RNG  = 2'b10;
  localparam logic [1:0] MODE_BP   = 2'b11;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_TERM  = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The driver reads its memory only once playback has started.
  function automatic logic [1:0] state_mode(input state_t s);
    return (s == ST_RUN || s == ST_DONE) ? MODE_READ : MODE_LOAD;
  endfunction

endpackage

// File: rtl/oh_dsync.sv
// Two-flop synchronizer with asynchronous active-low reset.
module oh_dsync (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], din};
  end

  assign dout = sync_q[1];

endmodule

// File: rtl/oh_stimulus_loader.sv
// Packs host words into stimulus packets for the driver memory, appends a zero
// terminator, then starts playback and waits for the driver to report done.
import oh_stimulus_loader_pkg::*;

module oh_stimulus_loader #(
  parameter  int PW    = 80,
  parameter  int IW    = 32,
  parameter  int DEPTH = 8192,
  localparam int MAW   = $clog2(DEPTH)
) (
  input  logic          ext_clk,
  input  logic          nreset,
  input  logic          host_valid,
  input  logic [IW-1:0] host_data,
  input  logic          host_last,
  output logic          host_ready,
  input  logic          go,
  input  logic          stim_done,
  output logic          ext_valid,
  output logic [PW-1:0] ext_packet,
  output logic [1:0]    mode,
  output logic [MAW:0]  count,
  output logic          full,
  output logic          done,
  output state_t        state
);

  localparam int NW = (PW + IW - 1) / IW;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int AW = NW * IW;
  localparam logic [WW-1:0]  LAST_IDX  = WW'(NW - 1);
  localparam logic [MAW:0]   CAP_COUNT = (MAW + 1)'(DEPTH - 2);

  // Handshake: a host word transfers on a rising ext_clk edge where
  // host_valid and host_ready are both high; host_ready depends only on state.

  state_t          state_q, state_d;
  logic [WW-1:0]   widx_q;
  logic [AW-1:0]   asm_q, merged;
  logic            accept, complete, cap_hit, sync_done;
  logic            valid_q, valid_d;
  logic [PW-1:0]   packet_q, packet_d;
  logic [1:0]      mode_q;
  logic [MAW:0]    count_q, count_d;
  logic            full_q, full_d;

  oh_dsync u_done_sync (
    .clk    (ext_clk),
    .nreset (nreset),
    .din    (stim_done),
    .dout   (sync_done)
  );

  assign host_ready = (state_q == ST_LOAD);
  assign accept     = host_valid & host_ready;
  assign complete   = accept & ((widx_q == LAST_IDX) | host_last);
  // This packet is the last one that still leaves room for the terminator.
  assign cap_hit    = (count_q == CAP_COUNT);

  always_comb begin
    merged = asm_q;
    merged[int'(widx_q) * IW +: IW] = host_data;
  end

  always_ff @(posedge ext_clk or negedge nreset) begin
    if (!nreset) state_q <= ST_LOAD;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (complete && (host_last || cap_hit)) state_d = ST_TERM;
      ST_TERM:  state_d = ST_ARMED;
      ST_ARMED: if (go) state_d = ST_RUN;
      ST_RUN:   if (sync_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    valid_d  = 1'b0;
    packet_d = packet_q;
    full_d   = full_q;
    case (state_q)
      ST_LOAD: begin
        if (complete) begin
          valid_d  = 1'b1;
          packet_d = merged[PW-1:0];
          if (cap_hit) full_d = 1'b1;
        end
      end
      ST_TERM: begin
        valid_d  = 1'b1;
        packet_d = '0;
      end
      default: ;
    endcase
    count_d = count_q + {{MAW{1'b0}}, valid_d};
  end

  always_ff @(posedge ext_clk or negedge nreset) begin
    if (!nreset) begin
      valid_q  <= 1'b0;
      packet_q <= '0;
      mode_q   <= MODE_LOAD;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      packet_q <= packet_d;
      mode_q   <= state_mode(state_d);
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Assembly restarts from a clean, all-zero packet after every completion.
  always_ff @(posedge ext_clk or negedge nreset) begin
    if (!nreset) begin
      widx_q <= '0;
      asm_q  <= '0;
    end else if (accept) begin
      if (complete) begin
        widx_q <= '0;
        asm_q  <= '0;
      end else begin
        widx_q <= widx_q + 1'b1;
        asm_q  <= merged;
      end
    end
  end

  assign ext_valid  = valid_q;
  assign ext_packet = packet_q;
  assign mode       = mode_q;
  assign count      = count_q;
  assign full       = full_q;
  assign done       = (state_q == ST_DONE);
  assign state      = state_q;

endmodule

// File: tb/tb_oh_stimulus_loader.sv
// Directed bench: packet assembly, terminator, capacity limit, playback
// handshake and mid-packet reset for oh_stimulus_loader.
module tb_oh_stimulus_loader;
  import oh_stimulus_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic ext_clk = 1'b0;
  logic nreset  = 1'b0;
  always #5 ext_clk = ~ext_clk;

  int cyc = 0;
  always @(posedge ext_clk) cyc <= cyc + 1;

  // ---------------- main DUT (defaults) ----------------
  logic        host_valid = 1'b0, host_last = 1'b0, go = 1'b0, stim_done = 1'b0;
  logic [31:0] host_data = '0;
  logic        host_ready, ext_valid, full, done;
  logic [79:0] ext_packet;
  logic [1:0]  mode;
  logic [13:0] count;
  state_t      st;

  oh_stimulus_loader dut (
    .ext_clk(ext_clk), .nreset(nreset), .host_valid(host_valid), .host_data(host_data),
    .host_last(host_last), .host_ready(host_ready), .go(go), .stim_done(stim_done),
    .ext_valid(ext_valid), .ext_packet(ext_packet), .mode(mode), .count(count),
    .full(full), .done(done), .state(st)
  );

  // ---------------- small-memory DUT ----------------
  logic        s_host_valid = 1'b0, s_go = 1'b0, s_stim_done = 1'b0;
  logic        s_host_last = 1'b0;
  logic [31:0] s_host_data = 32'h5A5A5A5A;
  logic        s_host_ready, s_ext_valid, s_full, s_done;
  logic [79:0] s_ext_packet;
  logic [1:0]  s_mode;
  logic [2:0]  s_count;
  state_t      s_st;

  oh_stimulus_loader #(.PW(80), .IW(32), .DEPTH(4)) dut_small (
    .ext_clk(ext_clk), .nreset(nreset), .host_valid(s_host_valid), .host_data(s_host_data),
    .host_last(s_host_last), .host_ready(s_host_ready), .go(s_go), .stim_done(s_stim_done),
    .ext_valid(s_ext_valid), .ext_packet(s_ext_packet), .mode(s_mode), .count(s_count),
    .full(s_full), .done(s_done), .state(s_st)
  );

  // ---------------- monitors / scoreboard ----------------
  logic [79:0] got_q[$];
  logic [79:0] exp_q[$];
  int          t_q[$];
  logic [79:0] s_pkts[$];
  int          s_acc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(negedge ext_clk) begin
    if (ext_valid) begin
      got_q.push_back(ext_packet);
      t_q.push_back(cyc);
    end
    if (s_ext_valid) s_pkts.push_back(s_ext_packet);
  end

  always @(posedge ext_clk) if (s_host_valid && s_host_ready) s_acc <= s_acc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_packets(input string tag);
    check({tag, "_npkt"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pkt%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    t_q.delete();
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_word(input logic [31:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    host_valid = 1'b1;
    host_data  = d;
    host_last  = l;
    for (int i = 0; i < 20; i++) begin
      if (host_ready) begin
        @(posedge ext_clk);
        ok = 1'b1;
        @(negedge ext_clk);
        break;
      end
      @(negedge ext_clk);
    end
    check("host_accept", 128'(ok), 128'(1));
  endtask

  task automatic idle();
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    idle();
    go = 1'b0;
    stim_done = 1'b0;
    repeat (2) @(negedge ext_clk);
    got_q.delete();
    exp_q.delete();
    t_q.delete();
    nreset = 1'b1;
    @(negedge ext_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;

    // Reset values, during and after reset.
    repeat (2) @(negedge ext_clk);
    check("rst_ext_valid", 128'(ext_valid), 128'(0));
    check("rst_ext_packet", 128'(ext_packet), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    nreset = 1'b1;
    @(negedge ext_clk);
    check("rst_host_ready", 128'(host_ready), 128'(1));
    check("rst_mode", 128'(mode), 128'(MODE_LOAD));
    check("rst_full", 128'(full), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_state", 128'(st), 128'(ST_LOAD));

    // Capacity limit on DEPTH=4: 3 data packets + terminator, 4th packet stalled.
    s_host_valid = 1'b1;
    repeat (40) @(negedge ext_clk);
    check("cap_host_ready", 128'(s_host_ready), 128'(0));
    check("cap_full", 128'(s_full), 128'(1));
    check("cap_count", 128'(s_count), 128'(4));
    check("cap_state", 128'(s_st), 128'(ST_ARMED));
    check("cap_words_accepted", 128'(s_acc), 128'(9));
    check("cap_npkt", 128'(s_pkts.size()), 128'(4));
    if (s_pkts.size() == 4) begin
      check("cap_pkt0", 128'(s_pkts[0]), 128'(80'h5A5A_5A5A5A5A_5A5A5A5A));
      check("cap_pkt2", 128'(s_pkts[2]), 128'(80'h5A5A_5A5A5A5A_5A5A5A5A));
      check("cap_term", 128'(s_pkts[3]), 128'(0));
    end
    s_host_valid = 1'b0;

    // Three full words -> one packet with the third word truncated.
    do_reset();
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    idle();
    check("full_pkt_valid", 128'(ext_valid), 128'(1));
    check("full_pkt_data", 128'(ext_packet), 128'(80'h3333_22222222_11111111));
    @(negedge ext_clk);
    check("full_pkt_pulse_end", 128'(ext_valid), 128'(0));
    check("full_pkt_count", 128'(count), 128'(1));
    check("full_pkt_state", 128'(st), 128'(ST_LOAD));
    exp_q.push_back(80'h3333_22222222_11111111);
    compare_packets("full_pkt");

    // go in LOAD ignored; short program via host_last then terminator.
    do_reset();
    go = 1'b1;
    @(negedge ext_clk);
    go = 1'b0;
    check("go_in_load_state", 128'(st), 128'(ST_LOAD));
    check("go_in_load_mode", 128'(mode), 128'(MODE_LOAD));
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b1);
    idle();
    repeat (3) @(negedge ext_clk);
    exp_q.push_back(80'h0000_22222222_11111111);
    exp_q.push_back(80'h0);
    compare_packets("last");
    check("last_count", 128'(count), 128'(2));
    check("last_state", 128'(st), 128'(ST_ARMED));
    check("last_host_ready", 128'(host_ready), 128'(0));
    check("last_full", 128'(full), 128'(0));

    // stim_done in ARMED ignored.
    stim_done = 1'b1;
    @(negedge ext_clk);
    stim_done = 1'b0;
    repeat (5) @(negedge ext_clk);
    check("armed_done_ignored_state", 128'(st), 128'(ST_ARMED));
    check("armed_done_ignored_done", 128'(done), 128'(0));

    // go in ARMED -> RUN, read mode next cycle.
    go = 1'b1;
    @(negedge ext_clk);
    go = 1'b0;
    check("run_mode", 128'(mode), 128'(MODE_READ));
    check("run_state", 128'(st), 128'(ST_RUN));

    // stim_done pulse -> done within 3 cycles, sticky.
    stim_done = 1'b1;
    waited = 0;
    while (waited < 8) begin
      @(negedge ext_clk);
      waited++;
      if (waited == 1) stim_done = 1'b0;
      if (done) break;
    end
    stim_done = 1'b0;
    check("done_seen", 128'(done), 128'(1));
    check("done_latency_le3", 128'(waited <= 3), 128'(1));
    go = 1'b1;
    repeat (4) @(negedge ext_clk);
    go = 1'b0;
    check("done_sticky", 128'(done), 128'(1));
    check("done_state", 128'(st), 128'(ST_DONE));
    check("done_mode", 128'(mode), 128'(MODE_READ));

    // Reset mid-packet discards the partial packet; reload works.
    do_reset();
    send_word(32'hDEADBEEF, 1'b0);
    idle();
    nreset = 1'b0;
    repeat (2) @(negedge ext_clk);
    nreset = 1'b1;
    @(negedge ext_clk);
    check("midrst_npkt", 128'(got_q.size()), 128'(0));
    check("midrst_count", 128'(count), 128'(0));
    check("midrst_mode", 128'(mode), 128'(MODE_LOAD));
    send_word(32'hAAAAAAAA, 1'b0);
    send_word(32'hBBBBBBBB, 1'b0);
    send_word(32'hCCCCCCCC, 1'b0);
    idle();
    @(negedge ext_clk);
    exp_q.push_back(80'hCCCC_BBBBBBBB_AAAAAAAA);
    compare_packets("midrst_reload");

    // host_last without host_valid ignored; continuous streaming.
    do_reset();
    host_last = 1'b1;
    @(negedge ext_clk);
    host_last = 1'b0;
    check("stray_last_state", 128'(st), 128'(ST_LOAD));
    for (int w = 1; w <= 6; w++) send_word({4{8'(w)}}, 1'b0);
    idle();
    @(negedge ext_clk);
    check("stream_count", 128'(count), 128'(2));
    check("stream_state", 128'(st), 128'(ST_LOAD));
    if (t_q.size() == 2) check("stream_spacing", 128'(t_q[1] - t_q[0]), 128'(3));
    else check("stream_pulses", 128'(t_q.size()), 128'(2));
    exp_q.push_back(80'h0303_02020202_01010101);
    exp_q.push_back(80'h0606_05050505_04040404);
    compare_packets("stream");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oh_stimulus_loader.md
OH_STIMULUS_LOADER -- requirements
Module: oh_stimulus_loader

Interface
REQ-001 SHALL have parameter PW, default 80: stimulus packet width, equal to the downstream stimulus driver's PW.
REQ-002 SHALL have parameter IW, default 32: host word width; NW = ceil(PW/IW) words per packet.
REQ-003 SHALL have parameter DEPTH, default 8192: stimulus memory depth; MAW = $clog2(DEPTH).
REQ-004 SHALL have reset nreset, asynchronous, active-low, and clock ext_clk.
REQ-005 ports: ext_clk in 1 write-side clock; nreset in 1 async reset.
REQ-006 ports: host_valid in 1 word valid; host_data in IW word; host_last in 1 final word of program; host_ready out 1 word accepted when high with host_valid.
REQ-007 ports: go in 1 start-playback request; stim_done in 1 done from driver (dut_clk domain).
REQ-008 ports: ext_valid out 1 packet write strobe; ext_packet out PW packet to driver memory; mode out 2 driver mode.
REQ-009 ports: count out MAW+1 packets written incl. terminator; full out 1 memory capacity reached; done out 1 playback finished.

Function
REQ-010 SHALL implement states LOAD, TERM, ARMED, RUN, DONE; LOAD after reset.
REQ-011 host_ready SHALL be high only in LOAD; a word is accepted on host_valid & host_ready.
REQ-012 Accepted word k (0..NW-1) SHALL occupy ext_packet[k*IW +: IW], truncated at PW-1; word index wraps to 0 after word NW-1.
REQ-013 ext_valid SHALL pulse exactly one cycle, the cycle after the packet-completing word is accepted (latency 1); ext_packet stable while ext_valid high.
REQ-014 A packet SHALL complete on word NW-1 or on host_last, whichever first; unfilled upper words SHALL be zero.
REQ-015 Word-index and assembly register SHALL clear after each completed packet.
REQ-016 count SHALL increment on every ext_valid pulse; saturation is impossible by REQ-018.
REQ-017 On completion of a packet carrying host_last: LOAD -> TERM.
REQ-018 On completion of a packet leaving count == DEPTH-1: LOAD -> TERM and full set (sticky); host_last on that same packet gives the same transition.
REQ-019 In TERM, one cycle: ext_valid=1, ext_packet=all zeros (bit0=0 end marker), then -> ARMED.
REQ-020 ARMED -> RUN on go; go in any other state SHALL be ignored.
REQ-021 mode SHALL be 2'b00 (load) in LOAD/TERM/ARMED and 2'b01 (read) in RUN/DONE; registered output.
REQ-022 stim_done SHALL be 2-flop synchronized into ext_clk; RUN -> DONE on synchronized high.
REQ-023 Synchronized stim_done outside RUN SHALL be ignored.
REQ-024 DONE SHALL be terminal; done=1 in DONE only; exit only via nreset.
REQ-025 host_last with host_valid low SHALL be ignored.

Reset
REQ-026 On nreset low: state LOAD, host_ready 1 after deassertion, ext_valid 0, ext_packet 0, mode 2'b00, count 0, full 0, done 0, synchronizer 0.
REQ-027 Reset mid-packet SHALL discard the partial packet with no ext_valid.

Structure
REQ-028 Mode encodings (MODE_LOAD, MODE_READ, MODE_RNG, MODE_BP) SHALL live in a shared header used by both loader and stimulus driver.
REQ-029 stim_done synchronizer SHALL be the existing oh_dsync sub-module; all else inline.

Verification
REQ-030 PW=80,IW=32: words 0x11111111,0x22222222,0x33333333 -> one ext_valid, ext_packet=0x3333_22222222_11111111, count=1.
REQ-031 Two words, second with host_last -> packet 0x0000_22222222_11111111, then zero terminator packet, count=2, state ARMED, host_ready=0.
REQ-032 DEPTH=4, 5 packets offered -> 3 data packets + terminator, full=1, host_ready=0, 4th packet's words stalled.
REQ-033 go during LOAD ignored; go in ARMED -> mode=01 next cycle; stim_done pulse -> done=1 within 3 cycles, sticky.
REQ-034 nreset asserted after 1 of 3 words -> no ext_valid, count=0, mode=00; reload of 3 words -> correct packet.
REQ-035 host_valid held high continuously -> one ext_valid per NW cycles, no lost words.
